// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants and types for the 8-way round-robin arbiter.
//   N        : number of requesters
//   IDX_W    : width of the encoded grant index (log2 N)
//   MAX_HOLD : longest grant, in cycles, when ARB_TIMEOUT_EN is defined
//   HOLD_W   : width of the hold counter that tracks grant length
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;
  localparam int HOLD_W   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. The request vector is rotated so
// that bit ptr lands at position 0, the lowest set bit is found, and that
// offset is added back to ptr to give the winner in the original numbering.
// Ports:
//   req      in  [N-1:0]      request vector
//   ptr      in  [IDX_W-1:0]  highest-priority requester this cycle
//   pick     out [N-1:0]      one-hot winner (zero when no request)
//   pick_idx out [IDX_W-1:0]  binary index of the winner
//   any      out              at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] off;

  // Rotation index arithmetic wraps naturally because N == 2**IDX_W.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N; i++) begin
      req_rot[i] = req[IDX_W'(i) + ptr];
    end
  end

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off = IDX_W'(i);
      end
    end
  end

  assign any      = |req;
  assign pick_idx = ptr + off;

  always_comb begin
    pick = '0;
    for (int i = 0; i < N; i++) begin
      pick[i] = any && (pick_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter sharing one resource among N requesters. A grant is
// held until the owner pulses rel or drops its request; the priority pointer
// then moves just past the served requester, leaving one dead cycle between
// owners.
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, a grant still held on its MAX_HOLD-th cycle
//                   is forced off and tmo pulses for one cycle. When
//                   undefined, grants last indefinitely and tmo is tied 0.
//
// Ports:
//   clk      in               rising-edge clock
//   rst      in               synchronous active-high reset
//   req      in  [N-1:0]      request vector
//   rel      in               single-cycle release from the current owner
//   gnt      out [N-1:0]      registered one-hot grant
//   gnt_idx  out [IDX_W-1:0]  registered binary index of the grant
//   gnt_vld  out              a grant is held
//   tmo      out              one-cycle pulse on forced release
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; pick a winner from req using the rotating pointer
// GRANT | owner holds the resource until rel, withdrawal or timeout
// -----------------------------------------------------------------------------
module rr_arbiter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             rel,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             tmo
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             vld_nxt;
  logic             release_now;
  logic             force_off;

  logic [N-1:0]     pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick_gnt),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      gnt_vld <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    vld_nxt     = gnt_vld;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        idx_nxt = '0;
        vld_nxt = 1'b0;
        if (pick_any) begin
          state_nxt = GRANT;
          gnt_nxt   = pick_gnt;
          idx_nxt   = pick_idx;
          vld_nxt   = 1'b1;
        end
      end
      GRANT: begin
        // rel and withdrawal together are a single release.
        release_now = rel || !req[gnt_idx];
        if (release_now || force_off) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          idx_nxt   = '0;
          vld_nxt   = 1'b0;
          ptr_nxt   = gnt_idx + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;

  // hold_cnt counts completed grant cycles; it sits at zero in IDLE so every
  // new grant starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      tmo      <= 1'b0;
    end else begin
      if (state == GRANT && state_nxt == GRANT) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt <= '0;
      end
      // A normal release on the same edge takes precedence over the timeout.
      tmo <= force_off && !release_now;
    end
  end

  assign force_off = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  assign force_off = 1'b0;
  assign tmo       = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
// Scoreboard bench: the stimulus process drives req/rel/rst on the falling
// edge, advances a behavioural model of the arbiter and queues the outputs
// expected after the next rising edge. The monitor samples just after each
// rising edge and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

  localparam int NR        = 8;
  localparam int HOLD_MAX  = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic          rel = 1'b0;
  logic [NR-1:0] gnt;
  logic [2:0]    gnt_idx;
  logic          gnt_vld;
  logic          tmo;

  rr_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [2:0]    idx;
    logic          vld;
    logic          tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   grants_seen = 0;
  int   tmo_seen = 0;

  // Reference model state: who owns the resource (-1 = nobody), the
  // requester with top priority, and how many cycles the owner has held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_tmo   = 1'b0;

  function automatic void model_step(input bit r, input logic [NR-1:0] q, input bit l);
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_tmo   = 1'b0;
    end else if (m_owner < 0) begin
      m_tmo = 1'b0;
      for (int k = 0; k < NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (q[c]) begin
          m_owner = c;
          m_hold  = 1;
          break;
        end
      end
    end else begin
      m_tmo = 1'b0;
      if (l || !q[m_owner]) begin
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
      end else if (TMO_EN && m_hold == HOLD_MAX) begin
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
        m_tmo   = 1'b1;
      end else begin
        m_hold = m_hold + 1;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt = (m_owner >= 0) ? NR'(1) << m_owner : '0;
    e.idx = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    e.vld = (m_owner >= 0);
    e.tmo = m_tmo;
    return e;
  endfunction

  task automatic step(input bit r, input logic [NR-1:0] q, input bit l);
    @(negedge clk);
    rst = r;
    req = q;
    rel = l;
    model_step(r, q, l);
    exp_q.push_back(model_out());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("gnt",     32'(gnt),     32'(e.gnt));
      check("gnt_idx", 32'(gnt_idx), 32'(e.idx));
      check("gnt_vld", 32'(gnt_vld), 32'(e.vld));
      check("tmo",     32'(tmo),     32'(e.tmo));
      if (e.vld) grants_seen++;
      if (e.tmo) tmo_seen++;
    end
  end

  initial begin
    logic [NR-1:0] rq;
    int            rel_div;

    // Reset, with arbitrary req to show reset wins.
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'h00, 1'b0);

    // Single requester, then rel (ptr moves to 1).
    step(1'b0, 8'h01, 1'b0);
    step(1'b0, 8'h01, 1'b0);
    step(1'b0, 8'h01, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Reset to ptr=0, then alternate between idx 2 and 7.
    step(1'b1, 8'h00, 1'b0);
    for (int g = 0; g < 4; g++) begin
      step(1'b0, 8'h84, 1'b0);
      step(1'b0, 8'h84, 1'b1);
    end

    // ptr wrapped to 0 after serving 7: all-request picks 0.
    step(1'b0, 8'hFF, 1'b0);
    step(1'b0, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Withdrawal: grant 3, drop req[3] with req[5] up.
    step(1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h28, 1'b0);
    step(1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h20, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Reset in the middle of a grant to 4.
    step(1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h10, 1'b0);
    step(1'b1, 8'h10, 1'b1);
    step(1'b0, 8'hFF, 1'b0);
    step(1'b0, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Long hold of requester 1 (timeout build forces it off).
    step(1'b1, 8'h00, 1'b0);
    for (int c = 0; c < HOLD_MAX + 4; c++) step(1'b0, 8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Randomised traffic: frequent releases, then rare ones.
    rq = 8'($urandom);
    for (int seg = 0; seg < 2; seg++) begin
      rel_div = (seg == 0) ? 4 : 40;
      for (int c = 0; c < 1500; c++) begin
        int sel;
        sel = int'($urandom_range(0, 15));
        if (sel == 0)      rq = 8'($urandom);
        else if (sel == 1) rq[$urandom_range(0, NR - 1)] ^= 1'b1;
        step(($urandom_range(0, 399) == 0),
             rq,
             ($urandom_range(0, rel_div - 1) == 0));
      end
    end
    step(1'b0, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    if (grants_seen == 0) begin
      errors++;
      $display("FAIL no_grants: got %0d grant cycles, expected some", grants_seen);
    end
    if (TMO_EN && tmo_seen == 0) begin
      errors++;
      $display("FAIL no_timeouts: got %0d tmo pulses, expected some", tmo_seen);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one downstream resource (a single-owner datapath such as the priority encoder or a shared bus port) among 8 requesters. Each cycle in IDLE, a rotating-priority pick selects at most one active request and produces a one-hot grant plus a 3-bit encoded index. The grant is held until the owner releases it or withdraws its request. Fairness comes from a pointer that advances past each served winner.

## Interface
- N, 8, number of requesters (fixed 8 in this revision)
- IDX_W, 3, width of encoded grant index (log2 N)
- MAX_HOLD, 16, maximum grant length in cycles when timeout is compiled in (≥2)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  request vector; bit k = requester k wants the resource
- rel  input  1  single-cycle release pulse from the current owner / resource
- gnt  output  N  one-hot grant, registered
- gnt_idx  output  IDX_W  binary index of granted requester, registered
- gnt_vld  output  1  high while any grant is held
- tmo  output  1  one-cycle pulse on forced release (timeout build only; constant 0 otherwise)

## Operation
- Reset values: gnt=0, gnt_idx=0, gnt_vld=0, tmo=0, ptr=0, state=IDLE, hold counter=0.
- State IDLE: if req≠0, the pick is the first set bit scanning upward from ptr, cyclically (ptr, ptr+1, …, 7, 0, …, ptr−1). Register gnt/gnt_idx/gnt_vld and go to GRANT. If req=0, stay IDLE with outputs 0.
- State GRANT: outputs held stable. Release occurs when rel=1 or req[gnt_idx]=0 (withdrawal). On release: outputs clear, ptr ← (gnt_idx+1) mod 8 (7 wraps to 0), go to IDLE.
- rel in IDLE is ignored. rel and withdrawal in the same cycle count as one release.
- Changes on non-granted req bits during GRANT have no effect.
- gnt is always one-hot or zero. gnt_idx equals the encoded position of gnt whenever gnt_vld=1.

## Timing
- Request latency: req sampled at edge t in IDLE → gnt valid after edge t (visible cycle t+1).
- Release latency: rel sampled at edge t → gnt=0 after edge t. The next grant is issued no earlier than edge t+1, so there is one dead cycle between owners. Minimum grant length is 1 cycle; minimum grant period is 2 cycles.
- rst asserted mid-GRANT: outputs and ptr return to reset values at that edge. No release or tmo pulse is generated.
- rst has priority over every other event.

## Configuration
- ARB_TIMEOUT_EN defined: the hold counter increments each GRANT cycle. If the grant is still held on its MAX_HOLD-th cycle with no release, it is forced off at that edge: tmo=1 for exactly one cycle, ptr advances as for a normal release, and state returns to IDLE. If a normal release lands on the same edge, it wins and tmo stays 0. The counter clears on every entry to GRANT.
- ARB_TIMEOUT_EN undefined: no counter; a grant is held indefinitely until release or withdrawal; tmo is tied 0.

## Structure
- Package arb_pkg: N, IDX_W, the state enum (IDLE, GRANT), and the MAX_HOLD default.
- Sub-module rr_pick is purely combinational: inputs req and ptr; outputs one-hot pick, its index, and an any flag. It rotates req by ptr, priority-encodes lowest-first, then un-rotates. The top holds the FSM, the pointer, the output registers and the optional counter.

## Test plan
- Reset, then req=8'b0000_0001 → gnt=8'h01, gnt_idx=0 one cycle later. rel pulse → gnt=0 next cycle, ptr=1.
- With ptr=0, req=8'b1000_0100 held and rel pulsed each grant → grants alternate idx 2, 7, 2, 7, with one dead cycle between each.
- Winner idx 7 released → ptr wraps to 0. With req=8'hFF, the next grant is idx 0.
- During a grant to idx 3, drop req[3] while req[5]=1 → gnt clears next cycle, then gnt_idx=5 one cycle later. No rel is needed.
- rst pulsed mid-grant (idx 4) → gnt=0, gnt_vld=0, tmo=0 after the edge. The next request from 8'hFF grants idx 0.
- ARB_TIMEOUT_EN, MAX_HOLD=16: hold req[1] with no rel → gnt drops after 16 grant cycles, tmo high for exactly 1 cycle, ptr=2.
